// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction prefetch front end.
//   fetchState_t  : request FSM states (IDLE, WAIT, DISCARD)
//   fetchEntry_t  : one FIFO entry, {instruction, PC+4}
//   NOP_INSTR     : word presented to IF/ID when nothing valid is buffered
//   PC_STEP       : sequential fetch increment
//   wordAlign()   : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetchState_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetchEntry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched {instruction, PC+4} entries.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_flush      : empties the FIFO (wins over push and pop)
//   i_push       : write i_data at the tail
//   i_pop        : drop the head entry
//   i_data       : entry to write
//   o_head       : entry at the head, read straight from storage registers
//   o_count      : number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  fetchEntry_t                i_data,
    output fetchEntry_t                o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetchEntry_t   r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          w_doPush;
    logic          w_doPop;

    // Guard against overflow/underflow so a stray request cannot corrupt state
    assign w_doPush = i_push && (r_count != FULL);
    assign w_doPop  = i_pop  && (r_count != '0);

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PW'(1);
            r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
        end
    end

    // Storage needs no reset: the head is only looked at when count is non-zero
    always_ff @(posedge i_clk) begin
        if (w_doPush && !i_flush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_prefetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_prefetch_queue
// Fetch front end between the instruction memory port and IF/ID. Issues one
// outstanding request at a time, buffers returned words and presents
// {instruction, PC+4}; flushes and refetches on a taken-branch redirect.
//   CLK, RST        : clock, asynchronous active-high reset
//   redirect_valid  : taken branch, flush and refetch from redirect_pc
//   redirect_pc     : branch target (low two bits ignored)
//   stall           : hold the output (no pop)
//   imem_req/addr   : memory request and its word-aligned address
//   imem_ack/rdata  : memory returns a word this cycle
//   out_valid       : head entry valid
//   out_instr       : head instruction, NOP when not valid
//   out_pc_4        : head address + 4, 0 when not valid
// ---------------------------------------------------------------------------
module instruction_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetchState_t   r_state;
    fetchState_t   w_stateNext;
    logic [31:0]   r_fetchPc;
    logic [31:0]   w_fetchPcNext;
    logic [31:0]   r_reqAddr;
    logic [31:0]   w_reqAddrNext;
    logic [31:0]   w_reqAddrStep;
    logic [31:0]   w_redirectPc;
    logic          w_push;
    logic          w_pop;
    logic          w_outValid;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_countIfPush;
    fetchEntry_t   w_head;
    fetchEntry_t   w_pushData;

    assign w_redirectPc  = wordAlign(redirect_pc);
    assign w_reqAddrStep = r_reqAddr + PC_STEP;

    // The valid mask hides the head during a redirect so the flushed entry is never popped
    assign w_outValid    = (w_count != '0) && !redirect_valid;
    assign w_pop         = w_outValid && !stall;

    // Occupancy after this edge if a word is pushed now; decides whether to chain the next request
    assign w_countIfPush = w_count + CW'(1) - CW'(w_pop);

    assign w_pushData.instr = imem_rdata;
    assign w_pushData.pc4   = w_reqAddrStep;

    // Next-state logic for the request FSM, fetch PC and request address
    always_comb begin
        w_stateNext   = r_state;
        w_fetchPcNext = r_fetchPc;
        w_reqAddrNext = r_reqAddr;
        w_push        = 1'b0;
        case (r_state)
            IDLE: begin
                if (redirect_valid) begin
                    w_fetchPcNext = w_redirectPc;
                    w_reqAddrNext = w_redirectPc;
                    w_stateNext   = WAIT;
                end else if (w_count != FULL) begin
                    w_reqAddrNext = r_fetchPc;
                    w_stateNext   = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    // A request without its ack cannot be withdrawn, so wait it out in DISCARD
                    w_fetchPcNext = w_redirectPc;
                    if (imem_ack) begin
                        w_reqAddrNext = w_redirectPc;
                    end else begin
                        w_stateNext = DISCARD;
                    end
                end else if (imem_ack) begin
                    w_push        = 1'b1;
                    w_fetchPcNext = w_reqAddrStep;
                    if (w_countIfPush < FULL) begin
                        w_reqAddrNext = w_reqAddrStep;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end
            end
            DISCARD: begin
                // A redirect landing on the ack cycle goes straight to the newest target
                if (redirect_valid) begin
                    w_fetchPcNext = w_redirectPc;
                    if (imem_ack) begin
                        w_reqAddrNext = w_redirectPc;
                        w_stateNext   = WAIT;
                    end
                end else if (imem_ack) begin
                    w_reqAddrNext = r_fetchPc;
                    w_stateNext   = WAIT;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State, fetch PC and request address registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_fetchPc <= wordAlign(RESET_PC);
            r_reqAddr <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_fetchPc <= w_fetchPcNext;
            r_reqAddr <= w_reqAddrNext;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pushData),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign imem_req  = (r_state == WAIT) || (r_state == DISCARD);
    assign imem_addr = r_reqAddr;
    assign out_valid = w_outValid;
    assign out_instr = w_outValid ? w_head.instr : NOP_INSTR;
    assign out_pc_4  = w_outValid ? w_head.pc4   : 32'h0;

endmodule
